// File: rtl/aes_pkg.sv
// aes_pkg: shared S-box tables, state enum and sizing helper for aes_sub_bytes_iter.
package aes_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t;

    localparam byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam byte_t INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic int beat_count(input int nbytes, input int lanes);
        return nbytes / lanes;
    endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// aes_sbox_lane: one combinational forward/inverse S-box lane.
// AES_SBOX_FAULT_CHECK_EN adds chk_ok, a round-trip check through the opposite table.
module aes_sbox_lane
    import aes_pkg::*;
(
    input  byte_t in_byte,
    input  logic  inv,
    output byte_t out_byte
`ifdef AES_SBOX_FAULT_CHECK_EN
    ,
    output logic  chk_ok
`endif
);

    assign out_byte = inv ? INV_SBOX[in_byte] : SBOX[in_byte];

`ifdef AES_SBOX_FAULT_CHECK_EN
    assign chk_ok = ((inv ? SBOX[out_byte] : INV_SBOX[out_byte]) == in_byte);
`endif

endmodule

// File: rtl/aes_sub_bytes_iter.sv
// aes_sub_bytes_iter: iterative SubBytes/InvSubBytes over LANES lanes, NBYTES/LANES beats.
// AES_SBOX_FAULT_CHECK_EN enables the sticky lane consistency check and output blanking.
module aes_sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int NBYTES = 16,
    parameter int LANES  = 4
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8*NBYTES-1:0] in_data,
    input  logic                in_inv,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*NBYTES-1:0] out_data,
    output logic                busy,
    output logic                fault
);

    localparam int NB = beat_count(NBYTES, LANES);
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;

    sub_state_t          state_q;
    logic [BW-1:0]       beat_q;
    logic [8*NBYTES-1:0] work_q;
    logic                mode_q;
    logic                fault_q;
    logic                beat_fault;
    byte_t               lane_in  [LANES];
    byte_t               lane_out [LANES];

`ifdef AES_SBOX_FAULT_CHECK_EN
    logic [LANES-1:0] lane_ok;
    assign beat_fault = ~&lane_ok;
`else
    assign beat_fault = 1'b0;
`endif

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign lane_in[i] = work_q[(int'(beat_q) * LANES + i) * 8 +: 8];
        aes_sbox_lane u_lane (
            .in_byte  (lane_in[i]),
            .inv      (mode_q),
            .out_byte (lane_out[i])
`ifdef AES_SBOX_FAULT_CHECK_EN
            ,
            .chk_ok   (lane_ok[i])
`endif
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            work_q  <= '0;
            mode_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    work_q  <= in_data;
                    mode_q  <= in_inv;
                    beat_q  <= '0;
                    fault_q <= 1'b0;
                    state_q <= RUN;
                end
                RUN: begin
                    for (int j = 0; j < LANES; j++)
                        work_q[(int'(beat_q) * LANES + j) * 8 +: 8] <= lane_out[j];
                    fault_q <= fault_q | beat_fault;
                    beat_q  <= beat_q + 1'b1;
                    if (beat_q == BW'(NB - 1))
                        state_q <= DONE;
                end
                DONE: if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // in_ready is gated by rst_n so it reads 0 for the whole reset assertion
    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign fault     = fault_q && out_valid;
    assign out_data  = fault ? '0 : work_q;

endmodule

// File: tb/tb_aes_sub_bytes_iter.sv
// tb_aes_sub_bytes_iter: scoreboard bench with an arithmetic GF(2^8) S-box model.
module tb_aes_sub_bytes_iter;

    localparam int NBYTES = 16;
    localparam int LANES  = 4;
    localparam int NB     = NBYTES / LANES;
    localparam int W      = 8 * NBYTES;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_inv;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         busy;
    logic         fault;

    logic [7:0]   fwd_t [256];
    logic [7:0]   inv_t [256];
    logic [W-1:0] exp_q [$];
    int           n_checks = 0;
    int           n_fail   = 0;

    always #5 clk = ~clk;

    aes_sub_bytes_iter #(.NBYTES(NBYTES), .LANES(LANES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_inv    (in_inv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .fault     (fault)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int s);
        return (v << s) | (v >> (8 - s));
    endfunction

    function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic inv);
        logic [W-1:0] r;
        for (int k = 0; k < NBYTES; k++)
            r[8*k +: 8] = inv ? inv_t[d[8*k +: 8]] : fwd_t[d[8*k +: 8]];
        return r;
    endfunction

    task automatic build_tables();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] iv = 8'h00;
            logic [7:0] b;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
            b = iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3) ^ rotl(iv, 4) ^ 8'h63;
            fwd_t[x] = b;
            inv_t[b] = 8'(x);
        end
    endtask

    function automatic logic [W-1:0] rnd_block();
        logic [W-1:0] r;
        for (int k = 0; k < W / 32; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", W'(in_ready), W'(1));
    endtask

    task automatic run_txn(input logic [W-1:0] d, input logic inv, input logic [W-1:0] exp, input int hold);
        int n;
        logic [W-1:0] got;
        wait_ready();
        in_valid  = 1'b1;
        in_data   = d;
        in_inv    = inv;
        out_ready = (hold == 0);
        exp_q.push_back(exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = rnd_block();
        in_inv   = ~inv;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", W'(n), W'(NB));
        check("ready_busy_done", W'({in_ready, busy, fault}), W'(3'b010));
        got = out_data;
        if (hold > 0) begin
            in_valid = 1'b1;
            in_data  = rnd_block();
            repeat (hold) begin
                @(posedge clk); #1;
                check("bp_stable", {out_data[W-3:0], out_valid, in_ready}, {got[W-3:0], 2'b10});
            end
            in_valid = 1'b0;
            @(negedge clk);
            out_ready = 1'b1;
        end
        check("data", got, exp_q.pop_front());
        if (hold > 0) begin
            @(posedge clk); #1;
            check("idle_after_done", W'({out_valid, in_ready, busy}), W'(3'b010));
        end
    endtask

    initial begin
        logic [W-1:0] seq, a, b;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_inv    = 1'b0;
        out_ready = 1'b1;
        build_tables();
        #23;
        check("rst_ctrl", W'({in_ready, out_valid, busy, fault}), W'(0));
        check("rst_data", out_data, W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_after_rst", W'(in_ready), W'(1));

        run_txn('0, 1'b1, {NBYTES{8'h52}}, 0);
        for (int k = 0; k < NBYTES; k++) seq[8*k +: 8] = 8'(k);
        run_txn(seq, 1'b0, 128'h76abd7fe2b670130c56f6bf27b777c63, 0);
        run_txn({NBYTES{8'h53}}, 1'b0, {NBYTES{8'hed}}, 0);
        run_txn({NBYTES{8'hed}}, 1'b1, {NBYTES{8'h53}}, 0);
        run_txn({NBYTES{8'h63}}, 1'b1, {NBYTES{8'h00}}, 0);
        run_txn({NBYTES{8'h00}}, 1'b0, {NBYTES{8'h63}}, 0);
        a = rnd_block();
        run_txn(a, 1'b0, model(a, 1'b0), 10);
        a = rnd_block();
        run_txn(a, 1'b1, model(a, 1'b1), 3);

        wait_ready();
        in_valid = 1'b1;
        in_data  = rnd_block();
        in_inv   = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrun_rst_ctrl", W'({in_ready, out_valid, busy, fault}), W'(0));
        check("midrun_rst_data", out_data, W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(seq, 1'b0, 128'h76abd7fe2b670130c56f6bf27b777c63, 0);

        for (int t = 0; t < 1000; t++) begin
            a = rnd_block();
            b = model(a, 1'b0);
            run_txn(a, 1'b0, b, 0);
            run_txn(b, 1'b1, a, 0);
        end

`ifdef AES_SBOX_FAULT_CHECK_EN
        wait_ready();
        in_valid = 1'b1;
        in_data  = seq;
        in_inv   = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        force dut.g_lane[0].u_lane.out_byte = 8'hff;
        @(posedge clk); #1;
        release dut.g_lane[0].u_lane.out_byte;
        repeat (NB - 2) begin
            @(posedge clk); #1;
        end
        check("fault_flag", W'({out_valid, fault}), W'(2'b11));
        check("fault_blank", out_data, W'(0));
        run_txn(seq, 1'b0, 128'h76abd7fe2b670130c56f6bf27b777c63, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
